mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_lane_decode.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM state codes, access
// size codes and the grant-history type.
package mem_port_arbiter_pkg;

    localparam logic [1:0] STATE_ARB_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ARB_GNT_IF = 2'd1;
    localparam logic [1:0] STATE_ARB_GNT_LS = 2'd2;
    localparam logic [1:0] STATE_ARB_RESP   = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = STATE_ARB_IDLE,
        GNT_IF = STATE_ARB_GNT_IF,
        GNT_LS = STATE_ARB_GNT_LS,
        RESP   = STATE_ARB_RESP
    } arb_state_t;

    typedef enum logic {
        LAST_IF = 1'b0,
        LAST_LS = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    // Requesters raise *_req with a stable payload and hold it until their
    // one-cycle *_ack; the arbiter holds mem_req and its payload stable until
    // mem_ready is sampled high, and mem_rdata is valid in that same cycle.
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [1:0]    ls_size;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_ack;
    logic [31:0]   ls_rdata;
    logic          ls_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output ls_ack, ls_rdata, ls_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  ls_ack, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_lane_decode.sv
// Byte-enable, store-data lane replication and alignment check for a
// load/store access, purely combinational.
module mem_lane_decode
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        bad_access
);

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = wdata;
        bad_access = 1'b0;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                bad_access = addr_lo[0];
            end
            SIZE_W: begin
                be         = 4'b1111;
                bad_access = (addr_lo != 2'b00);
            end
            default: begin
                // size code 3 has no meaning; reject it like a misaligned access
                be         = 4'b0000;
                bad_access = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store. Optional mem_ready timeout is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus,
    output arb_state_t        state_dbg
);

    arb_state_t    state;
    gnt_t          last_gnt;

    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   mem_wdata_q;
    logic          if_ack_q;
    logic [31:0]   if_rdata_q;
    logic          ls_ack_q;
    logic          ls_err_q;
    logic [31:0]   ls_rdata_q;

    logic [3:0]    ls_be;
    logic [31:0]   ls_wdata_rep;
    logic          ls_bad;
    logic          if_wins;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);
    logic [4:0] to_cnt;
`endif

    mem_lane_decode u_lane_decode (
        .size       (bus.ls_size),
        .addr_lo    (bus.ls_addr[1:0]),
        .wdata      (bus.ls_wdata),
        .be         (ls_be),
        .wdata_rep  (ls_wdata_rep),
        .bad_access (ls_bad)
    );

    // On a tie the requester that did not win last time goes first.
    assign if_wins = bus.if_req && (!bus.ls_req || (last_gnt == LAST_LS));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            last_gnt    <= LAST_LS;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_ack_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt      <= 5'd0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            ls_ack_q <= 1'b0;
            ls_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_wins) begin
                        state       <= GNT_IF;
                        last_gnt    <= LAST_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {bus.if_addr[AW-1:2], 2'b00};
                        mem_be_q    <= 4'b1111;
                        mem_wdata_q <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
                        to_cnt      <= 5'd0;
`endif
                    end else if (bus.ls_req) begin
                        last_gnt <= LAST_LS;
                        if (ls_bad) begin
                            // rejected accesses never reach the memory
                            state    <= RESP;
                            ls_ack_q <= 1'b1;
                            ls_err_q <= 1'b1;
                        end else begin
                            state       <= GNT_LS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.ls_we;
                            mem_addr_q  <= {bus.ls_addr[AW-1:2], 2'b00};
                            mem_be_q    <= ls_be;
                            mem_wdata_q <= ls_wdata_rep;
`ifdef MEM_ARB_TIMEOUT_EN
                            to_cnt      <= 5'd0;
`endif
                        end
                    end
                end
                GNT_IF, GNT_LS: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state     <= RESP;
                        if (state == GNT_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            ls_rdata_q <= bus.mem_rdata;
                            ls_ack_q   <= 1'b1;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (to_cnt == TIMEOUT_LAST) begin
                        // give up: a fetch completes as a zero (nop) word
                        mem_req_q <= 1'b0;
                        state     <= RESP;
                        if (state == GNT_IF) begin
                            if_rdata_q <= 32'h0000_0000;
                            if_ack_q   <= 1'b1;
                        end else begin
                            ls_ack_q <= 1'b1;
                            ls_err_q <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 5'd1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_ack    = ls_ack_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign state_dbg     = state;

    // fetch addresses are word aligned, so their low bits carry nothing
    logic unused_bits;
`ifdef MEM_ARB_TIMEOUT_EN
    assign unused_bits = ^bus.if_addr[1:0];
`else
    assign unused_bits = ^{bus.if_addr[1:0], 32'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized
// fetch/load/store traffic checked against a spec-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW      = 32;
    localparam int TIMEOUT = 16;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    arb_state_t state_dbg;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
        bit            chk_wdata;
        logic [31:0]   rdata;
        int            lat;
        bit            stall;
        int            stall_cycles;
    } mem_exp_t;

    typedef struct {
        bit          is_ls;
        logic        err;
        logic [31:0] rdata;
    } rsp_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   rdata;
        int            lat;
        bit            stall;
    } if_txn_t;

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        int            lat;
        bit            stall;
    } ls_txn_t;

    mem_exp_t exp_mem_q[$];
    rsp_exp_t exp_rsp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit          model_last_ls;
    logic [31:0] model_if_rdata;
    logic [31:0] model_ls_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd3) ? 0 : (1 << size);
    endfunction

    function automatic bit model_bad(input logic [1:0] size, input logic [AW-1:0] addr);
        int nb;
        nb = size_bytes(size);
        if (nb == 0) return 1'b1;
        return (int'(addr[1:0]) % nb) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [AW-1:0] addr);
        int nb;
        nb = size_bytes(size);
        return 4'(((1 << nb) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        int nb;
        nb = size_bytes(size);
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] addr);
        return addr - AW'(addr % 4);
    endfunction

    task automatic expect_if(input if_txn_t t);
        mem_exp_t m;
        rsp_exp_t r;
        m = '{we: 1'b0, addr: word_addr(t.addr), be: 4'hF, wdata: 32'h0, chk_wdata: 1'b0,
              rdata: t.rdata, lat: t.lat, stall: t.stall, stall_cycles: t.stall ? TIMEOUT : 0};
        exp_mem_q.push_back(m);
        model_if_rdata = t.stall ? 32'h0 : t.rdata;
        r = '{is_ls: 1'b0, err: 1'b0, rdata: model_if_rdata};
        exp_rsp_q.push_back(r);
        model_last_ls = 1'b0;
    endtask

    task automatic expect_ls(input ls_txn_t t);
        mem_exp_t m;
        rsp_exp_t r;
        if (model_bad(t.size, t.addr)) begin
            r = '{is_ls: 1'b1, err: 1'b1, rdata: model_ls_rdata};
        end else begin
            m = '{we: t.we, addr: word_addr(t.addr), be: model_be(t.size, t.addr),
                  wdata: model_wdata(t.size, t.wdata), chk_wdata: t.we, rdata: t.rdata,
                  lat: t.lat, stall: t.stall, stall_cycles: t.stall ? TIMEOUT : 0};
            exp_mem_q.push_back(m);
            if (!t.stall) model_ls_rdata = t.rdata;
            r = '{is_ls: 1'b1, err: t.stall, rdata: model_ls_rdata};
        end
        exp_rsp_q.push_back(r);
        model_last_ls = 1'b1;
    endtask

    task automatic model_reset();
        model_last_ls  = 1'b1;
        model_if_rdata = 32'h0;
        model_ls_rdata = 32'h0;
    endtask

    // ---------------- driver ----------------
    task automatic run_txns(input bit do_if, input if_txn_t it, input bit do_ls, input ls_txn_t lt,
                            output int ls_cycles);
        bit if_done;
        bit ls_done;
        int cyc;
        if (do_if && do_ls) begin
            if (model_last_ls) begin expect_if(it); expect_ls(lt); end
            else               begin expect_ls(lt); expect_if(it); end
        end else if (do_if) begin
            expect_if(it);
        end else if (do_ls) begin
            expect_ls(lt);
        end
        @(negedge clk);
        if (do_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = it.addr;
        end
        if (do_ls) begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = lt.we;
            bus.ls_size  = lt.size;
            bus.ls_addr  = lt.addr;
            bus.ls_wdata = lt.wdata;
        end
        if_done   = !do_if;
        ls_done   = !do_ls;
        cyc       = 0;
        ls_cycles = 0;
        while (!(if_done && ls_done) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!if_done && bus.if_ack) begin bus.if_req = 1'b0; if_done = 1'b1; end
            if (!ls_done && bus.ls_ack) begin bus.ls_req = 1'b0; ls_done = 1'b1; ls_cycles = cyc; end
        end
        check("acks_seen", {30'd0, if_done, ls_done}, 32'd3);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    initial begin
        mem_exp_t x;
        int n;
        bit known;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bus.mem_ready = 1'b0;
            end else if (bus.mem_req) begin
                bus.mem_ready = 1'b0;
                known = (exp_mem_q.size() != 0);
                if (!known) begin
                    check("mem_unexpected_req", 32'd1, 32'd0);
                    x = '{we: 1'b0, addr: '0, be: 4'h0, wdata: 32'h0, chk_wdata: 1'b0,
                          rdata: 32'h0, lat: 0, stall: 1'b0, stall_cycles: 0};
                end else begin
                    x = exp_mem_q.pop_front();
                    check("mem_we", bus.mem_we, x.we);
                    check("mem_addr", bus.mem_addr, x.addr);
                    check("mem_be", bus.mem_be, x.be);
                    if (x.chk_wdata) check("mem_wdata", bus.mem_wdata, x.wdata);
                end
                if (x.stall) begin
                    n = 0;
                    while (bus.mem_req && n < 300) begin
                        n++;
                        @(negedge clk);
                    end
                    check("stall_req_released", bus.mem_req, 1'b0);
                    if (x.stall_cycles > 0) begin
                        check("timeout_cycles", n, x.stall_cycles);
                        check("timeout_ack", bus.if_ack | bus.ls_ack, 1'b1);
                    end
                end else begin
                    for (int i = 0; i < x.lat; i++) begin
                        @(negedge clk);
                        check("mem_hold_req", bus.mem_req, 1'b1);
                        check("mem_hold_addr", bus.mem_addr, x.addr);
                    end
                    bus.mem_rdata = x.rdata;
                    bus.mem_ready = 1'b1;
                    @(negedge clk);
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    check("mem_req_drop", bus.mem_req, 1'b0);
                    check("ack_after_ready", bus.if_ack | bus.ls_ack, 1'b1);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                // stray ready while no access is outstanding must be ignored
                bus.mem_ready = 1'b1;
                bus.mem_rdata = $urandom;
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        rsp_exp_t r;
        bit prev_if_ack;
        bit prev_ls_ack;
        prev_if_ack = 1'b0;
        prev_ls_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_if_ack = 1'b0;
                prev_ls_ack = 1'b0;
            end else begin
                if (bus.if_ack || bus.ls_ack) begin
                    check("ack_one_cycle", (bus.if_ack & prev_if_ack) | (bus.ls_ack & prev_ls_ack), 1'b0);
                    if (exp_rsp_q.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_port_if", bus.if_ack, !r.is_ls);
                        check("rsp_port_ls", bus.ls_ack, r.is_ls);
                        if (r.is_ls) begin
                            check("ls_err", bus.ls_err, r.err);
                            check("ls_rdata", bus.ls_rdata, r.rdata);
                        end else begin
                            check("if_rdata", bus.if_rdata, r.rdata);
                        end
                    end
                end
                prev_if_ack = bus.if_ack;
                prev_ls_ack = bus.ls_ack;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        if_txn_t it;
        ls_txn_t lt;
        mem_exp_t m;
        int cyc;
        int mode;

        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_size   = 2'd0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        check("rst_state", state_dbg, IDLE);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_be", bus.mem_be, 4'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_if_ack", bus.if_ack, 1'b0);
        check("rst_ls_ack", bus.ls_ack, 1'b0);
        check("rst_ls_err", bus.ls_err, 1'b0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_ls_rdata", bus.ls_rdata, 32'h0);
        #2 rstn = 1'b1;

        // simultaneous requests right after reset, then a repeated tie
        it = '{addr: 32'h0000_0100, rdata: 32'h1111_0001, lat: 1, stall: 1'b0};
        lt = '{we: 1'b1, size: SIZE_W, addr: 32'h0000_0200, wdata: 32'hCAFE_0001,
               rdata: 32'h2222_0002, lat: 0, stall: 1'b0};
        run_txns(1'b1, it, 1'b1, lt, cyc);
        it = '{addr: 32'h0000_0104, rdata: 32'h3333_0003, lat: 0, stall: 1'b0};
        lt = '{we: 1'b0, size: SIZE_H, addr: 32'h0000_0206, wdata: 32'h0,
               rdata: 32'h4444_0004, lat: 2, stall: 1'b0};
        run_txns(1'b1, it, 1'b1, lt, cyc);

        // fetch alone with a two-cycle memory
        it = '{addr: 32'h0000_0040, rdata: 32'h2402_0005, lat: 2, stall: 1'b0};
        run_txns(1'b1, it, 1'b0, lt, cyc);

        // byte store to the top lane
        lt = '{we: 1'b1, size: SIZE_B, addr: 32'h0000_1003, wdata: 32'h0000_00AB,
               rdata: 32'h5555_0005, lat: 1, stall: 1'b0};
        run_txns(1'b0, it, 1'b1, lt, cyc);

        // misaligned word load: rejected without a memory access
        lt = '{we: 1'b0, size: SIZE_W, addr: 32'h0000_1002, wdata: 32'h0,
               rdata: 32'h0, lat: 0, stall: 1'b0};
        run_txns(1'b0, it, 1'b1, lt, cyc);
        check("misaligned_ack_latency", cyc, 32'd1);

        // illegal size code
        lt = '{we: 1'b1, size: 2'd3, addr: 32'h0000_2000, wdata: 32'h1234_5678,
               rdata: 32'h0, lat: 0, stall: 1'b0};
        run_txns(1'b0, it, 1'b1, lt, cyc);
        check("illegal_ack_latency", cyc, 32'd1);

        // reset pulse while a load/store is waiting on memory
        m = '{we: 1'b0, addr: 32'h0000_3000, be: 4'hF, wdata: 32'h0, chk_wdata: 1'b0,
              rdata: 32'h0, lat: 0, stall: 1'b1, stall_cycles: 0};
        exp_mem_q.push_back(m);
        @(negedge clk);
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_size = SIZE_W;
        bus.ls_addr = 32'h0000_3000;
        for (int i = 0; i < 20 && state_dbg != GNT_LS; i++) @(negedge clk);
        check("rst_mid_gnt_ls", state_dbg, GNT_LS);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_mem_req", bus.mem_req, 1'b0);
        check("rst_mid_state", state_dbg, IDLE);
        check("rst_mid_ls_ack", bus.ls_ack, 1'b0);
        bus.ls_req = 1'b0;
        model_reset();
        @(negedge clk);
        #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_ls_ack", bus.ls_ack, 1'b0);
        end
        it = '{addr: 32'h0000_0080, rdata: 32'h6666_0006, lat: 1, stall: 1'b0};
        run_txns(1'b1, it, 1'b0, lt, cyc);

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers: load/store ends with an error, fetch with a nop
        lt = '{we: 1'b0, size: SIZE_W, addr: 32'h0000_4000, wdata: 32'h0,
               rdata: 32'h0, lat: 0, stall: 1'b1};
        run_txns(1'b0, it, 1'b1, lt, cyc);
        it = '{addr: 32'h0000_4100, rdata: 32'hDEAD_BEEF, lat: 0, stall: 1'b1};
        run_txns(1'b1, it, 1'b0, lt, cyc);
`endif

        // randomized mix of fetches, loads/stores and ties
        for (int k = 0; k < 60; k++) begin
            mode = $urandom_range(0, 2);
            it = '{addr: {$urandom} & 32'hFFFF_FFFC, rdata: $urandom,
                   lat: $urandom_range(0, 4), stall: 1'b0};
            lt = '{we: 1'($urandom_range(0, 1)), size: 2'($urandom_range(0, 3)),
                   addr: $urandom, wdata: $urandom, rdata: $urandom,
                   lat: $urandom_range(0, 4), stall: 1'b0};
            run_txns(mode != 1, it, mode != 0, lt, cyc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("mem_queue_drained", exp_mem_q.size(), 32'd0);
        check("rsp_queue_drained", exp_rsp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
